// File: rtl/instruction_sequencer.sv
// Instruction sequencer: accepts one instruction word over a valid/ready
// handshake, latches the opcode and operands, then steps a one-hot timestep
// vector T until the decoder reports done. Illegal opcodes and instructions
// that run past the last timestep end in ERROR until err_clear.
module instruction_sequencer #(
  parameter int STEPS = 5,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [11:0]      instr,
  input  logic             done,
  input  logic             stall,
  input  logic             err_clear,
  output logic             instr_ready,
  output logic [STEPS-1:0] T,
  output logic [2:0]       opcode,
  output logic [2:0]       p1,
  output logic [2:0]       p2,
  output logic [2:0]       p3,
  output logic             busy,
  output logic             complete,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXEC     = 2'd1,
    S_COMPLETE = 2'd2,
    S_ERROR    = 2'd3
  } state_t;

  localparam logic [1:0]       ERR_NONE    = 2'b00;
  localparam logic [1:0]       ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]       ERR_TIMEOUT = 2'b10;
  localparam logic [STEPS-1:0] T_FIRST     = {{(STEPS-1){1'b0}}, 1'b1};

  state_t state, state_nxt;

  // Opcodes 000..100 are implemented; 101..111 are rejected at accept time.
  logic instr_legal;
  assign instr_legal = (instr[11:9] <= 3'b100);

  // Status outputs decode the registered state only, never the inputs.
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state == S_EXEC) || (state == S_COMPLETE);
  assign complete    = (state == S_COMPLETE);
  assign error       = (state == S_ERROR);

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; in EXEC stall outranks done, done outranks timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (instr_valid) state_nxt = instr_legal ? S_EXEC : S_ERROR;
      end
      S_EXEC: begin
        if (!stall) begin
          if (done)             state_nxt = S_COMPLETE;
          else if (T[STEPS-1])  state_nxt = S_ERROR;
        end
      end
      S_COMPLETE: state_nxt = S_IDLE;
      S_ERROR: begin
        if (err_clear) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, timestep shifter, error code and completion count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      T           <= '0;
      opcode      <= '0;
      p1          <= '0;
      p2          <= '0;
      p3          <= '0;
      err_code    <= ERR_NONE;
      instr_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) begin
            opcode <= instr[11:9];
            p1     <= instr[8:6];
            p2     <= instr[5:3];
            p3     <= instr[2:0];
            if (instr_legal) T        <= T_FIRST;
            else             err_code <= ERR_ILLEGAL;
          end
        end
        S_EXEC: begin
          if (!stall) begin
            if (done) begin
              T           <= '0;
              instr_count <= instr_count + 1'b1;
            end else if (T[STEPS-1]) begin
              T        <= '0;
              err_code <= ERR_TIMEOUT;
            end else begin
              T <= T << 1;
            end
          end
        end
        S_ERROR: begin
          if (err_clear) err_code <= ERR_NONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: each scenario drives a fixed
// cycle-by-cycle pattern and compares outputs to hand-computed values.
module tb_instruction_sequencer;

  localparam int STEPS = 5;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             instr_valid;
  logic [11:0]      instr;
  logic             done;
  logic             stall;
  logic             err_clear;
  logic             instr_ready;
  logic [STEPS-1:0] T;
  logic [2:0]       opcode, p1, p2, p3;
  logic             busy, complete, error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instr_count;

  int n_chk  = 0;
  int n_fail = 0;

  instruction_sequencer #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .done(done), .stall(stall), .err_clear(err_clear),
    .instr_ready(instr_ready), .T(T), .opcode(opcode), .p1(p1), .p2(p2),
    .p3(p3), .busy(busy), .complete(complete), .error(error),
    .err_code(err_code), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling or driving.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  int busy_cycles;
  logic [STEPS-1:0] t_exp [6];

  initial begin
    reset = 1'b0; instr_valid = 1'b0; instr = '0;
    done = 1'b0; stall = 1'b0; err_clear = 1'b0;
    tick; tick;
    // Reset state
    chk("rst_ready", instr_ready, 1);
    chk("rst_T", T, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_error", error, 0);
    chk("rst_errcode", err_code, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_complete", complete, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick;

    // Load: opcode 001, p1 011, done while T=00010
    instr = {3'b001, 3'b011, 3'b000, 3'b000}; instr_valid = 1'b1;
    tick;                                     // accept edge
    instr_valid = 1'b0; instr = '0;
    chk("ld_c1_T", T, 5'b00001);
    chk("ld_c1_ready", instr_ready, 0);
    chk("ld_c1_p1", p1, 3'b011);
    tick;
    chk("ld_c2_T", T, 5'b00010);
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("ld_c3_complete", complete, 1);
    chk("ld_c3_T", T, 0);
    chk("ld_c3_count", instr_count, 1);
    chk("ld_c3_ready", instr_ready, 0);
    tick;
    chk("ld_c4_ready", instr_ready, 1);
    chk("ld_c4_complete", complete, 0);
    chk("ld_c4_p1", p1, 3'b011);
    chk("ld_c4_opcode", opcode, 3'b001);

    // Add: 011_001_010_011, done while T=01000
    t_exp = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b00000, 5'b00000};
    busy_cycles = 0;
    instr = 12'b011_001_010_011; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0; instr = '0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("add_T_c%0d", c + 1), T, t_exp[c]);
      if (busy) busy_cycles++;
      done = (c == 3);
      if (c == 4) chk("add_complete", complete, 1);
      if (c < 5) tick;
    end
    done = 1'b0;
    chk("add_busy_cycles", busy_cycles, 5);
    chk("add_ready", instr_ready, 1);
    chk("add_opnds", {opcode, p1, p2, p3}, 12'b011_001_010_011);
    chk("add_count", instr_count, 2);

    // Timeout: opcode 000, done held low
    instr = {3'b000, 9'o123}; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    chk("to_c1_T", T, 5'b00001);
    tick; tick; tick; tick;
    chk("to_c5_T", T, 5'b10000);
    chk("to_c5_error", error, 0);
    tick;
    chk("to_error", error, 1);
    chk("to_errcode", err_code, 2'b10);
    chk("to_T", T, 0);
    chk("to_busy", busy, 0);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("to_clr_error", error, 0);
    chk("to_clr_errcode", err_code, 0);
    chk("to_clr_ready", instr_ready, 1);
    chk("to_count", instr_count, 2);

    // Illegal opcode 110
    instr = {3'b110, 3'b101, 3'b010, 3'b001}; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    chk("ill_error", error, 1);
    chk("ill_errcode", err_code, 2'b01);
    chk("ill_T", T, 0);
    chk("ill_opcode", opcode, 3'b110);
    instr = {3'b010, 9'o777}; instr_valid = 1'b1;   // ignored while in ERROR
    tick;
    instr_valid = 1'b0;
    chk("ill_hold_error", error, 1);
    chk("ill_hold_T", T, 0);
    chk("ill_hold_opnds", {opcode, p1, p2, p3}, {3'b110, 3'b101, 3'b010, 3'b001});
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    chk("ill_clr_ready", instr_ready, 1);
    chk("ill_clr_errcode", err_code, 0);

    // Stall at T=00100 for 3 cycles with done high
    instr = {3'b010, 9'o0}; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick; tick;
    chk("st_T", T, 5'b00100);
    stall = 1'b1; done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk($sformatf("st_hold_T%0d", c), T, 5'b00100);
      chk($sformatf("st_hold_cmp%0d", c), complete, 0);
    end
    stall = 1'b0;
    tick;
    done = 1'b0;
    chk("st_complete", complete, 1);
    chk("st_count", instr_count, 3);
    tick;
    chk("st_ready", instr_ready, 1);

    // Reset mid-instruction at T=00100
    instr = {3'b100, 9'o0}; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick; tick;
    chk("mr_T_pre", T, 5'b00100);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mr_T", T, 0);
    chk("mr_ready", instr_ready, 1);
    chk("mr_count", instr_count, 0);
    chk("mr_error", error, 0);
    chk("mr_opcode", opcode, 0);

    // 256 completions wrap the counter
    for (int i = 0; i < 256; i++) begin
      instr = {3'b000, 9'o0}; instr_valid = 1'b1;
      tick;
      instr_valid = 1'b0; done = 1'b1;
      tick;
      done = 1'b0;
      if (i == 254) chk("wrap_255", instr_count, 255);
      if (i == 255) begin
        chk("wrap_0", instr_count, 0);
        chk("wrap_complete", complete, 1);
      end
      tick;
    end
    chk("wrap_ready", instr_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Sequences the processor's combinational function decoder. The block accepts one instruction word through a valid/ready handshake and latches opcode and operands. It then walks a one-hot timestep vector T until the decoder reports done, and flags illegal opcodes and runaway instructions. It sits between the instruction source (switches or program memory) and the function decoder.

Parameters:
STEPS, 5, width of one-hot timestep vector T (maximum steps per instruction)
CNT_W, 8, width of completed-instruction counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset
instr_valid  input  1  instruction word on instr is valid
instr  input  12  {opcode[11:9], p1[8:6], p2[5:3], p3[2:0]}
done  input  1  decoder "instruction finished" flag, sampled in EXEC
stall  input  1  freezes sequencing while high
err_clear  input  1  leaves ERROR state
instr_ready  output  1  high in IDLE only
T  output  STEPS  one-hot timestep to decoder, all-zero outside EXEC
opcode  output  3  latched opcode
p1  output  3  latched operand 1
p2  output  3  latched operand 2
p3  output  3  latched operand 3
busy  output  1  high in EXEC and COMPLETE
complete  output  1  one-cycle pulse in COMPLETE
error  output  1  high in ERROR
err_code  output  2  01 illegal opcode, 10 timeout, 00 none
instr_count  output  CNT_W  count of completed instructions

Behaviour:
- Reset (reset==0 at edge, any state, including mid-instruction): state IDLE, T=0, opcode/p1/p2/p3=0, complete=0, error=0, err_code=00, instr_count=0. instr_ready=1 from the next cycle.
- All outputs are registered or decoded from the registered state. No combinational path from inputs to outputs.
- States: IDLE, EXEC, COMPLETE, ERROR.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1 at an edge, latch opcode/p1/p2/p3 from instr.
  - Legal opcode (000..100): next state EXEC, T=00001.
  - Illegal opcode (101..111): next state ERROR, err_code=01, T stays 0.
  - instr_valid=0: remain in IDLE.
- EXEC, evaluated at each edge in priority order:
  1. stall=1: hold state and T; done is ignored.
  2. done=1: go to COMPLETE, T=0.
  3. T[STEPS-1]=1 with done=0: go to ERROR, err_code=10, T=0.
  4. Otherwise: shift T left by one (T stays one-hot).
- COMPLETE:
  - Lasts exactly one cycle; complete=1.
  - instr_count increments on entry, wrapping 2^CNT_W-1 -> 0.
  - Next state IDLE unconditionally. stall is ignored.
- ERROR:
  - error=1; err_code and latched operands hold.
  - err_clear=1 at an edge: go to IDLE, err_code=00.
  - instr_valid is ignored.
- Latched opcode/p1..p3 hold through COMPLETE, ERROR and the following IDLE until the next accept.
- Latency: with done first asserted while T=bit k, complete is high in cycle k+2 after the accept edge and instr_ready is high in cycle k+3. Accept-to-accept minimum is k+3 cycles.
- Simultaneous reset and any other input: reset wins.

Test Plan:
- Load (opcode 001, p1=011), done asserted by decoder model while T=00010 -> T=00001, then 00010; complete pulse one cycle later; instr_count 0->1; instr_ready high again 4 cycles after the accept edge; p1 output =011 throughout.
- Add (instr=011_001_010_011), done at T=01000 -> T steps 00001,00010,00100,01000; complete on the following cycle; opcode/p1/p2/p3 = 011/001/010/011 held; busy high for 5 cycles.
- Timeout: legal opcode, done held 0 -> T reaches 10000, next cycle error=1, err_code=10, T=0; err_clear pulse -> IDLE, err_code=00, instr_ready=1.
- Illegal opcode 110 accepted -> no EXEC cycle (T never nonzero), error=1 and err_code=01 next cycle; instr_valid pulses during ERROR are ignored.
- Stall at T=00100 held for 3 cycles with done=1 during stall -> T remains 00100 and no completion; after stall drops, done is sampled and COMPLETE follows.
- reset=0 asserted while T=00100 -> next cycle T=0, state IDLE, instr_count=0, error=0; separately, 256 completions wrap instr_count 255 -> 0.
